// File: rtl/bcd_sevenseg_scan_if.sv
// Bus between the BCD converter / display pins and the seven-segment scanner.
// The master drives the packed BCD word and its load strobe; the slave drives the display pins.
interface bcd_sevenseg_scan_if;
  logic [15:0] bcd_d_in;
  logic        bcd_vld;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  modport master (output bcd_d_in, output bcd_vld, input an, input seg, input dp);
  modport slave  (input bcd_d_in, input bcd_vld, output an, output seg, output dp);
endinterface

// File: rtl/bcd_sevenseg_scan.sv
// Latches a 4-digit packed BCD word and scans it onto a common-anode display.
// Define BCD_LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 is always lit).
module bcd_sevenseg_scan #(
  parameter int REFRESH_DIV = 100000
) (
  input logic             clk,
  input logic             rst,
  bcd_sevenseg_scan_if.slave bus
);

  localparam int              CNT_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(REFRESH_DIV - 1);

  logic [15:0]      r_capture;
  logic [1:0]       r_idx;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_an;
  logic [6:0]       r_seg;

  logic [3:0] w_nibble;
  logic [6:0] w_digitSeg;
  logic [3:0] w_blank;
  logic [3:0] w_anNext;
  logic [6:0] w_segNext;

  // Select the nibble for the current slot and decode it; invalid BCD shows a dash
  always_comb begin
    w_nibble = 4'h0;
    case (r_idx)
      2'd0: w_nibble = r_capture[3:0];
      2'd1: w_nibble = r_capture[7:4];
      2'd2: w_nibble = r_capture[11:8];
      2'd3: w_nibble = r_capture[15:12];
      default: w_nibble = 4'h0;
    endcase

    w_digitSeg = 7'h3F;
    case (w_nibble)
      4'd0: w_digitSeg = 7'h40;
      4'd1: w_digitSeg = 7'h79;
      4'd2: w_digitSeg = 7'h24;
      4'd3: w_digitSeg = 7'h30;
      4'd4: w_digitSeg = 7'h19;
      4'd5: w_digitSeg = 7'h12;
      4'd6: w_digitSeg = 7'h02;
      4'd7: w_digitSeg = 7'h78;
      4'd8: w_digitSeg = 7'h00;
      4'd9: w_digitSeg = 7'h10;
      default: w_digitSeg = 7'h3F;
    endcase
  end

  // A digit is blanked only if it and every digit above it are zero
  always_comb begin
    w_blank = 4'b0000;
`ifdef BCD_LEADING_ZERO_BLANK_EN
    w_blank[3] = (r_capture[15:12] == 4'h0);
    w_blank[2] = w_blank[3] && (r_capture[11:8] == 4'h0);
    w_blank[1] = w_blank[2] && (r_capture[7:4] == 4'h0);
`endif
  end

  always_comb begin
    w_anNext  = ~(4'b0001 << r_idx);
    w_segNext = w_digitSeg;
    if (w_blank[r_idx]) begin
      w_anNext  = 4'b1111;
      w_segNext = 7'h7F;
    end
  end

  // Outputs are registered from the pre-edge index/capture, so they trail those by one clock
  always_ff @(posedge clk) begin
    if (rst) begin
      r_capture <= 16'h0000;
      r_idx     <= 2'd0;
      r_cnt     <= '0;
      r_an      <= 4'b1111;
      r_seg     <= 7'h7F;
    end else begin
      if (bus.bcd_vld) begin
        r_capture <= bus.bcd_d_in;
      end
      if (r_cnt == CNT_TERM) begin
        r_cnt <= '0;
        r_idx <= r_idx + 2'd1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      r_an  <= w_anNext;
      r_seg <= w_segNext;
    end
  end

  assign bus.an  = r_an;
  assign bus.seg = r_seg;
  assign bus.dp  = 1'b1;

endmodule
